// File: rtl/clock_ctrl.sv
// CPU clock sequencer: turns one free-running clk into a registered clock-enable
// for HALT / STEP / SLOW / RUN modes, with a debounced step button and a sticky halt latch.
module clock_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SLOW_DIV        = 5,
   parameter int CNT_W           = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_step,
   input  logic [1:0] mode,
   input  logic       halt_req,
   output logic       clk_en,
   output logic [1:0] mode_act,
   output logic       halted
);

   typedef enum logic [2:0] {
      S_HALT   = 3'd0,
      S_STEP   = 3'd1,
      S_SLOW   = 3'd2,
      S_RUN    = 3'd3,
      S_SWITCH = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SLOW_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   function automatic state_t mode_to_state(input logic [1:0] m);
      state_t s;
      case (m)
         2'b00:   s = S_HALT;
         2'b01:   s = S_STEP;
         2'b10:   s = S_SLOW;
         2'b11:   s = S_RUN;
         default: s = S_HALT;
      endcase
      return s;
   endfunction

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
   logic             btn_db_q, btn_db_d;
   logic             step_pulse_q, step_pulse_d;
   state_t           state_q, state_d;
   logic [1:0]       mode_act_q, mode_act_d;
   logic             halted_q, halted_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic             clk_en_q, clk_en_d;

   // Button synchronizer and debouncer; a level is accepted after DEBOUNCE_CYCLES mismatching samples.
   always_comb begin
      sync1_d  = btn_step;
      sync2_d  = sync1_q;
      db_cnt_d = '0;
      btn_db_d = btn_db_q;
      if (sync2_q != btn_db_q) begin
         if (db_cnt_q == DB_LAST) begin
            btn_db_d = sync2_q;
            db_cnt_d = '0;
         end else begin
            db_cnt_d = db_cnt_q + CNT_ONE;
         end
      end else begin
         db_cnt_d = '0;
      end
      step_pulse_d = btn_db_d & ~btn_db_q;
   end

   // Mode FSM: halt latch first, then the single idle SWITCH cycle between modes.
   always_comb begin
      state_d    = state_q;
      mode_act_d = mode_act_q;
      halted_d   = halted_q;
      if (halt_req) begin
         halted_d   = 1'b1;
         state_d    = S_HALT;
         mode_act_d = 2'b00;
      end else if (halted_q) begin
         state_d    = S_HALT;
         mode_act_d = 2'b00;
         if (mode == 2'b00) begin
            halted_d = 1'b0;
         end else begin
            halted_d = 1'b1;
         end
      end else begin
         case (state_q)
            S_SWITCH: begin
               state_d    = mode_to_state(mode);
               mode_act_d = mode;
            end
            S_HALT, S_STEP, S_SLOW, S_RUN: begin
               if (mode != mode_act_q) begin
                  state_d = S_SWITCH;
               end else begin
                  state_d = state_q;
               end
            end
            default: begin
               state_d    = S_HALT;
               mode_act_d = 2'b00;
            end
         endcase
      end
   end

   // Slow divider and clk_en decode; both look at the state being entered, so clk_en is glitch-free.
   always_comb begin
      div_d    = div_q;
      clk_en_d = 1'b0;
      if (state_d == S_SLOW) begin
         if (state_q != S_SLOW) begin
            div_d = '0;
         end else if (div_q == DIV_LAST) begin
            div_d = '0;
         end else begin
            div_d = div_q + CNT_ONE;
         end
      end else begin
         div_d = div_q;
      end
      case (state_d)
         S_RUN:   clk_en_d = 1'b1;
         S_STEP:  clk_en_d = step_pulse_q;
         S_SLOW:  clk_en_d = (div_d == DIV_LAST);
         default: clk_en_d = 1'b0;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         db_cnt_q     <= '0;
         btn_db_q     <= 1'b0;
         step_pulse_q <= 1'b0;
         state_q      <= S_HALT;
         mode_act_q   <= 2'b00;
         halted_q     <= 1'b0;
         div_q        <= '0;
         clk_en_q     <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         db_cnt_q     <= db_cnt_d;
         btn_db_q     <= btn_db_d;
         step_pulse_q <= step_pulse_d;
         state_q      <= state_d;
         mode_act_q   <= mode_act_d;
         halted_q     <= halted_d;
         div_q        <= div_d;
         clk_en_q     <= clk_en_d;
      end
   end

   assign clk_en   = clk_en_q;
   assign mode_act = mode_act_q;
   assign halted   = halted_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl: fixed vector table, hand-written step/slow/reset sequences,
// and a randomized run checked every cycle against a behavioural model.
module tb_clock_ctrl;

   localparam int DEB  = 4;
   localparam int SDIV = 5;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_step;
   logic [1:0] mode;
   logic       halt_req;
   logic       clk_en;
   logic [1:0] mode_act;
   logic       halted;

   int n_checks = 0;
   int n_fail   = 0;
   int en_count = 0;

   clock_ctrl #(.DEBOUNCE_CYCLES(DEB), .SLOW_DIV(SDIV), .CNT_W(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .btn_step (btn_step),
      .mode     (mode),
      .halt_req (halt_req),
      .clk_en   (clk_en),
      .mode_act (mode_act),
      .halted   (halted)
   );

   always #5 clk = ~clk;

   // Behavioural model: state as a plain integer (0..3 = mode, 4 = switching).
   logic       raw_q[$];
   logic       smp_q[$];
   logic       m_db, m_pulse, m_en, m_halted;
   logic [1:0] m_act;
   int         m_state, m_slow_n;

   task automatic model_edge();
      logic synced, all_diff;
      int   prev;
      if (!reset) begin
         raw_q.delete(); smp_q.delete();
         m_db = 1'b0; m_pulse = 1'b0; m_en = 1'b0; m_halted = 1'b0;
         m_act = 2'd0; m_state = 0; m_slow_n = 0;
      end else begin
         raw_q.push_front(btn_step);
         if (raw_q.size() > 4) void'(raw_q.pop_back());
         synced = (raw_q.size() > 2) ? raw_q[2] : 1'b0;
         smp_q.push_front(synced);
         if (smp_q.size() > DEB) void'(smp_q.pop_back());
         all_diff = (smp_q.size() == DEB);
         foreach (smp_q[i]) if (smp_q[i] == m_db) all_diff = 1'b0;

         prev = m_state;
         if (halt_req) begin
            m_halted = 1'b1; m_state = 0; m_act = 2'd0;
         end else if (m_halted) begin
            m_state = 0; m_act = 2'd0;
            if (mode == 2'd0) m_halted = 1'b0;
         end else if (m_state == 4) begin
            m_state = int'(mode); m_act = mode;
         end else if (mode != m_act) begin
            m_state = 4;
         end

         if (m_state == 2) m_slow_n = (prev == 2) ? m_slow_n + 1 : 1;
         m_en = (m_state == 3) || (m_state == 2 && (m_slow_n % SDIV) == 0)
                || (m_state == 1 && m_pulse);
         m_pulse = all_diff && !m_db;
         if (all_diff) m_db = ~m_db;
      end
   endtask

   task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("model_clk_en", {1'b0, clk_en}, {1'b0, m_en});
      check("model_mode_act", mode_act, m_act);
      check("model_halted", {1'b0, halted}, {1'b0, m_halted});
      if (clk_en === 1'b1) en_count++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   typedef struct {
      logic       rst;
      logic [1:0] md;
      logic       hr;
      logic       exp_en;
      logic [1:0] exp_act;
      logic       exp_halted;
   } vec_t;

   vec_t vecs[19];

   initial begin
      int hold;
      reset = 1'b0; btn_step = 1'b0; mode = 2'd3; halt_req = 1'b0;

      // reset with RUN requested, one SWITCH, RUN; RUN->SLOW->RUN bounce; halt and recovery
      vecs[0]  = '{1'b0, 2'd3, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[1]  = '{1'b0, 2'd3, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[2]  = '{1'b0, 2'd3, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[3]  = '{1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[4]  = '{1'b1, 2'd3, 1'b0, 1'b1, 2'd3, 1'b0};
      vecs[5]  = '{1'b1, 2'd3, 1'b0, 1'b1, 2'd3, 1'b0};
      vecs[6]  = '{1'b1, 2'd3, 1'b0, 1'b1, 2'd3, 1'b0};
      vecs[7]  = '{1'b1, 2'd2, 1'b0, 1'b0, 2'd3, 1'b0};
      vecs[8]  = '{1'b1, 2'd3, 1'b0, 1'b1, 2'd3, 1'b0};
      vecs[9]  = '{1'b1, 2'd3, 1'b0, 1'b1, 2'd3, 1'b0};
      vecs[10] = '{1'b1, 2'd3, 1'b1, 1'b0, 2'd0, 1'b1};
      vecs[11] = '{1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 1'b1};
      vecs[12] = '{1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 1'b1};
      vecs[13] = '{1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[14] = '{1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[15] = '{1'b1, 2'd3, 1'b0, 1'b1, 2'd3, 1'b0};
      vecs[16] = '{1'b1, 2'd3, 1'b0, 1'b1, 2'd3, 1'b0};
      vecs[17] = '{1'b1, 2'd0, 1'b0, 1'b0, 2'd3, 1'b0};
      vecs[18] = '{1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};

      for (int i = 0; i < 19; i++) begin
         reset = vecs[i].rst; mode = vecs[i].md; halt_req = vecs[i].hr;
         tick();
         check($sformatf("vec%0d_clk_en", i), {1'b0, clk_en}, {1'b0, vecs[i].exp_en});
         check($sformatf("vec%0d_mode_act", i), mode_act, vecs[i].exp_act);
         check($sformatf("vec%0d_halted", i), {1'b0, halted}, {1'b0, vecs[i].exp_halted});
      end

      // STEP: bouncy press then a held press gives exactly one pulse; a 3-cycle press gives none
      mode = 2'd1;
      ticks(2);
      check("step_entered", mode_act, 2'd1);
      en_count = 0;
      btn_step = 1'b1; ticks(2);
      btn_step = 1'b0; ticks(2);
      btn_step = 1'b1; ticks(10);
      btn_step = 1'b0; ticks(10);
      check("step_bounce_pulses", 2'(en_count), 2'd1);
      en_count = 0;
      btn_step = 1'b1; ticks(3);
      btn_step = 1'b0; ticks(10);
      check("step_short_press", 2'(en_count), 2'd0);

      // SLOW: pulse on every fifth cycle after entry
      mode = 2'd2;
      tick();
      check("slow_switch_idle", {1'b0, clk_en}, 2'd0);
      for (int i = 1; i <= 30; i++) begin
         tick();
         check($sformatf("slow_cycle%0d", i), {1'b0, clk_en}, {1'b0, (i % SDIV) == 0});
      end

      // Reset mid-debounce discards the press
      mode = 2'd1;
      ticks(2);
      btn_step = 1'b1; ticks(2);
      reset = 1'b0; btn_step = 1'b0; ticks(2);
      reset = 1'b1;
      en_count = 0;
      ticks(20);
      check("reset_discard_pulses", 2'(en_count), 2'd0);
      check("reset_then_step", mode_act, 2'd1);
      btn_step = 1'b1; ticks(8);
      btn_step = 1'b0; ticks(8);
      check("new_press_pulse", 2'(en_count), 2'd1);

      // Randomized run against the model
      hold = 1;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
         halt_req = ($urandom_range(0, 63) == 0);
         reset    = ($urandom_range(0, 299) != 0);
         hold--;
         if (hold <= 0) begin
            btn_step = ~btn_step;
            hold = $urandom_range(1, 8);
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
